// File: rtl/bw_io_ddr_vref_pkg.sv
// Shared types and helpers for the DDR Vref ramp controller and its ladder encoder.
package bw_io_ddr_vref_pkg;

    typedef enum logic {IDLE, RAMP} vref_state_t;

    // Bit i of the result is set when lvl is above i, for the low 'width' bits.
    function automatic logic [63:0] thermometer(input int lvl, input int width);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) t[i] = (lvl > i);
        end
        return t;
    endfunction

    function automatic int clamp(input int sel, input int lo, input int hi);
        if (sel < lo) return lo;
        if (sel > hi) return hi;
        return sel;
    endfunction

endpackage

// File: rtl/bw_io_ddr_vref_therm_enc.sv
// Combinational level-to-thermometer encoder, shared with the pad-side ladder model.
module bw_io_ddr_vref_therm_enc
    import bw_io_ddr_vref_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]        lvl,
    output logic [(2**SEL_W)-2:0]   therm
);

    localparam int NLVL = 2**SEL_W;

    always_comb begin
        therm = (NLVL-1)'(thermometer(32'(lvl), NLVL-1));
    end

endmodule

// File: rtl/bw_io_ddr_vref_ctl.sv
// DDR Vref controller: accepts a clamped target by handshake and ramps the live
// level one step per dwell period, driving a registered thermometer code.
module bw_io_ddr_vref_ctl
    import bw_io_ddr_vref_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int DWELL     = 4,
    parameter int LVL_MIN   = 0,
    parameter int LVL_MAX   = 7,
    parameter int RESET_LVL = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_req,
    input  logic [SEL_W-1:0]        upd_sel,
    output logic                    upd_ack,
    input  logic                    hold,
    output logic [SEL_W-1:0]        vref_lvl,
    output logic [(2**SEL_W)-2:0]   vref_therm,
    output logic                    busy,
    output logic                    done
);

    localparam int NLVL  = 2**SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD  = CNT_W'(DWELL-1);
    localparam logic [SEL_W-1:0]  RESET_SEL   = SEL_W'(RESET_LVL);
    localparam logic [NLVL-2:0]   RESET_THERM = (NLVL-1)'(thermometer(RESET_LVL, NLVL-1));

    vref_state_t       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [SEL_W-1:0]  tgt, tgt_n, lvl_n;
    logic [NLVL-2:0]   therm_n;
    logic              busy_n, done_n;

    bw_io_ddr_vref_therm_enc #(.SEL_W(SEL_W)) u_therm_enc (
        .lvl   (lvl_n),
        .therm (therm_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tgt        <= RESET_SEL;
            vref_lvl   <= RESET_SEL;
            vref_therm <= RESET_THERM;
            upd_ack    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            tgt        <= tgt_n;
            vref_lvl   <= lvl_n;
            vref_therm <= therm_n;
            upd_ack    <= upd_req;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // A step taken on the same edge as a request still heads toward the old target.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lvl_n   = vref_lvl;
        busy_n  = busy;
        done_n  = 1'b0;
        tgt_n   = upd_req ? SEL_W'(clamp(32'(upd_sel), LVL_MIN, LVL_MAX)) : tgt;

        case (state)
            IDLE: begin
                if (!hold && (tgt != vref_lvl)) begin
                    state_n = RAMP;
                    cnt_n   = CNT_RELOAD;
                    busy_n  = 1'b1;
                end
            end
            RAMP: begin
                if (hold) begin
                    state_n = RAMP;
                end else if (tgt == vref_lvl) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    lvl_n = (tgt > vref_lvl) ? vref_lvl + SEL_W'(1) : vref_lvl - SEL_W'(1);
                    cnt_n = CNT_RELOAD;
                    if (lvl_n == tgt) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bw_io_ddr_vref_ctl.sv
// Directed bench for bw_io_ddr_vref_ctl: default window instance plus a [2,6] window instance.
module tb_bw_io_ddr_vref_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic       upd_req, hold;
    logic [2:0] upd_sel;
    logic       upd_ack, busy, done;
    logic [2:0] vref_lvl;
    logic [6:0] vref_therm;

    logic       w_req, w_hold;
    logic [2:0] w_sel;
    logic       w_ack, w_busy, w_done;
    logic [2:0] w_lvl;
    logic [6:0] w_therm;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bw_io_ddr_vref_ctl dut (
        .clk        (clk),
        .reset      (reset),
        .upd_req    (upd_req),
        .upd_sel    (upd_sel),
        .upd_ack    (upd_ack),
        .hold       (hold),
        .vref_lvl   (vref_lvl),
        .vref_therm (vref_therm),
        .busy       (busy),
        .done       (done)
    );

    bw_io_ddr_vref_ctl #(.LVL_MIN(2), .LVL_MAX(6)) dutw (
        .clk        (clk),
        .reset      (reset),
        .upd_req    (w_req),
        .upd_sel    (w_sel),
        .upd_ack    (w_ack),
        .hold       (w_hold),
        .vref_lvl   (w_lvl),
        .vref_therm (w_therm),
        .busy       (w_busy),
        .done       (w_done)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] s, input logic h);
        upd_req = r;
        upd_sel = s;
        hold    = h;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0);
        w_req = 1'b0; w_sel = 3'd0; w_hold = 1'b0;
        tick(2);
        checkOutput("rst_lvl",   8'(vref_lvl),   8'd4);
        checkOutput("rst_therm", 8'(vref_therm), 8'h0f);
        checkOutput("rst_busy",  8'(busy),       8'd0);
        checkOutput("rst_ack",   8'(upd_ack),    8'd0);
        checkOutput("rst_done",  8'(done),       8'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("idle_lvl",  8'(vref_lvl),   8'd4);
        checkOutput("idle_busy", 8'(busy),       8'd0);

        // Window [2,6]: target 0 clamps to 2, target 7 clamps to 6.
        w_req = 1'b1; w_sel = 3'd0;
        tick(1);
        checkOutput("w_ack",     8'(w_ack),   8'd1);
        w_req = 1'b0;
        tick(1);
        checkOutput("w_busy",    8'(w_busy),  8'd1);
        checkOutput("w_ack_off", 8'(w_ack),   8'd0);
        tick(4);
        checkOutput("w_lvl3",    8'(w_lvl),   8'd3);
        tick(4);
        checkOutput("w_lvl2",    8'(w_lvl),   8'd2);
        checkOutput("w_done2",   8'(w_done),  8'd1);
        checkOutput("w_therm2",  8'(w_therm), 8'h03);
        tick(4);
        checkOutput("w_stay2",   8'(w_lvl),   8'd2);
        checkOutput("w_idle2",   8'(w_busy),  8'd0);
        w_req = 1'b1; w_sel = 3'd7;
        tick(1);
        w_req = 1'b0;
        tick(17);
        checkOutput("w_lvl6",    8'(w_lvl),   8'd6);
        checkOutput("w_done6",   8'(w_done),  8'd1);
        checkOutput("w_therm6",  8'(w_therm), 8'h3f);
        tick(4);
        checkOutput("w_stay6",   8'(w_lvl),   8'd6);
        checkOutput("w_idle6",   8'(w_busy),  8'd0);

        // Ramp 4 -> 7 with DWELL=4: steps land 5, 9 and 13 cycles after the ack.
        applyStimulus(1'b1, 3'd7, 1'b0);
        tick(1);
        checkOutput("up_ack",    8'(upd_ack),    8'd1);
        checkOutput("up_lvl_e1", 8'(vref_lvl),   8'd4);
        applyStimulus(1'b0, 3'd7, 1'b0);
        tick(1);
        checkOutput("up_busy",   8'(busy),       8'd1);
        checkOutput("up_ack_off",8'(upd_ack),    8'd0);
        tick(3);
        checkOutput("up_lvl_e5", 8'(vref_lvl),   8'd4);
        tick(1);
        checkOutput("up_lvl5",   8'(vref_lvl),   8'd5);
        checkOutput("up_therm5", 8'(vref_therm), 8'h1f);
        tick(3);
        checkOutput("up_lvl_e9", 8'(vref_lvl),   8'd5);
        tick(1);
        checkOutput("up_lvl6",   8'(vref_lvl),   8'd6);
        checkOutput("up_done_e10",8'(done),      8'd0);
        tick(4);
        checkOutput("up_lvl7",   8'(vref_lvl),   8'd7);
        checkOutput("up_therm7", 8'(vref_therm), 8'h7f);
        checkOutput("up_done",   8'(done),       8'd1);
        checkOutput("up_busy_off",8'(busy),      8'd0);
        tick(1);
        checkOutput("up_done_off",8'(done),      8'd0);

        // Ramp 7 -> 3 with a 10-cycle hold while cnt is 2.
        applyStimulus(1'b1, 3'd3, 1'b0);
        tick(1);
        applyStimulus(1'b0, 3'd3, 1'b0);
        tick(5);
        checkOutput("hd_lvl6",   8'(vref_lvl),   8'd6);
        tick(1);
        applyStimulus(1'b0, 3'd3, 1'b1);
        tick(10);
        checkOutput("hd_frozen", 8'(vref_lvl),   8'd6);
        checkOutput("hd_therm",  8'(vref_therm), 8'h3f);
        checkOutput("hd_busy",   8'(busy),       8'd1);
        applyStimulus(1'b0, 3'd3, 1'b0);
        tick(2);
        checkOutput("hd_resume_wait", 8'(vref_lvl), 8'd6);
        tick(1);
        checkOutput("hd_lvl5",   8'(vref_lvl),   8'd5);
        tick(8);
        checkOutput("hd_lvl3",   8'(vref_lvl),   8'd3);
        checkOutput("hd_done",   8'(done),       8'd1);
        tick(1);
        checkOutput("hd_busy_off", 8'(busy),     8'd0);

        // Async reset between clock edges while ramping at level 6.
        applyStimulus(1'b1, 3'd7, 1'b0);
        tick(1);
        applyStimulus(1'b0, 3'd7, 1'b0);
        tick(13);
        checkOutput("ar_lvl6",   8'(vref_lvl),   8'd6);
        checkOutput("ar_busy",   8'(busy),       8'd1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("ar_lvl",    8'(vref_lvl),   8'd4);
        checkOutput("ar_therm",  8'(vref_therm), 8'h0f);
        checkOutput("ar_busy0",  8'(busy),       8'd0);
        checkOutput("ar_done0",  8'(done),       8'd0);
        tick(1);
        reset = 1'b0;
        tick(2);
        checkOutput("ar_idle",   8'(busy),       8'd0);
        checkOutput("ar_hold4",  8'(vref_lvl),   8'd4);

        // Retarget from 7 to 1 while at level 5: reverses on the next step.
        applyStimulus(1'b1, 3'd7, 1'b0);
        tick(1);
        applyStimulus(1'b0, 3'd7, 1'b0);
        tick(5);
        checkOutput("rt_lvl5",   8'(vref_lvl),   8'd5);
        applyStimulus(1'b1, 3'd1, 1'b0);
        tick(1);
        checkOutput("rt_ack",    8'(upd_ack),    8'd1);
        applyStimulus(1'b0, 3'd1, 1'b0);
        tick(2);
        checkOutput("rt_wait",   8'(vref_lvl),   8'd5);
        tick(1);
        checkOutput("rt_lvl4",   8'(vref_lvl),   8'd4);
        checkOutput("rt_done_e", 8'(done),       8'd0);
        tick(12);
        checkOutput("rt_lvl1",   8'(vref_lvl),   8'd1);
        checkOutput("rt_therm1", 8'(vref_therm), 8'h01);
        checkOutput("rt_done",   8'(done),       8'd1);
        tick(1);
        checkOutput("rt_done_off", 8'(done),     8'd0);
        checkOutput("rt_busy_off", 8'(busy),     8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
